// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the single-precision multiplier back end.
// The stage-1 payload exponent is sized for incoming exponent sums up to 10 bits wide.
package fp_mul_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int FRAC_W     = 23;
  localparam int EXP_W_MAX  = 10;
  localparam int S1_EXP_W   = EXP_W_MAX + 1;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic                       sign;
    logic                       zero;
    logic signed [S1_EXP_W-1:0] exp;
    logic [FRAC_W-1:0]          frac;
    logic                       guard;
    logic                       sticky;
  } s1_payload_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction; carry flags the all-ones wrap.
module fp_round_rne
  import fp_mul_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac_rnd,
  output logic              carry
);

  logic round_up;

  // Ties (guard set, nothing below it) go to the even neighbour.
  assign round_up          = guard & (sticky | frac[0]);
  assign {carry, frac_rnd} = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};

endmodule

// File: rtl/fp_mul_norm_round.sv
// Normalize / round-to-nearest-even / pack stage of the FP multiplier.
// Two register stages with valid/ready flow control on both sides.
module fp_mul_norm_round
  import fp_mul_pkg::*;
#(
  parameter int PROD_W = 48,
  parameter int EXP_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [PROD_W-1:0]       in_mant,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic                    out_overflow,
  output logic                    out_underflow
);

  localparam logic signed [S1_EXP_W:0] EXP_SAT  = (S1_EXP_W+1)'(FP_EXP_MAX);
  localparam logic signed [S1_EXP_W:0] EXP_ZERO = '0;

  s1_payload_t s1_next, s1_q;
  logic        s1_valid;
  logic        s1_adv;

  assign s1_adv    = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;

  // Stage 1: the product is in [1,4); a set top bit means one right shift.
  always_comb begin
    // NOTE: every field gets a default before the branches so no latch is inferred.
    s1_next      = '0;
    s1_next.sign = in_sign;
    s1_next.zero = in_zero;
    if (in_mant[PROD_W-1]) begin
      s1_next.frac   = in_mant[PROD_W-2 -: FRAC_W];
      s1_next.guard  = in_mant[PROD_W-2-FRAC_W];
      s1_next.sticky = |in_mant[PROD_W-3-FRAC_W:0];
      s1_next.exp    = S1_EXP_W'(in_exp) + S1_EXP_W'(1);
    end else begin
      s1_next.frac   = in_mant[PROD_W-3 -: FRAC_W];
      s1_next.guard  = in_mant[PROD_W-3-FRAC_W];
      s1_next.sticky = |in_mant[PROD_W-4-FRAC_W:0];
      s1_next.exp    = S1_EXP_W'(in_exp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state is assigned with <= so every flop samples pre-edge values.
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: the payload is qualified by s1_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_q <= s1_next;
    end
  end

  // Stage 2: round, then apply zero > overflow > underflow > normal priority.
  logic [FRAC_W-1:0]      frac_rnd;
  logic                   carry;
  logic signed [S1_EXP_W:0] exp_rnd;
  fp32_t                  res_c;
  logic                   ovf_c, unf_c;

  fp_round_rne u_round (
    .frac     (s1_q.frac),
    .guard    (s1_q.guard),
    .sticky   (s1_q.sticky),
    .frac_rnd (frac_rnd),
    .carry    (carry)
  );

  assign exp_rnd = (S1_EXP_W+1)'(s1_q.exp) + (S1_EXP_W+1)'(carry);

  always_comb begin
    res_c      = '0;
    ovf_c      = 1'b0;
    unf_c      = 1'b0;
    res_c.sign = s1_q.sign;
    if (s1_q.zero) begin
      res_c.sign = s1_q.sign;
    end else if (exp_rnd >= EXP_SAT) begin
      res_c.exp = 8'hFF;
      ovf_c     = 1'b1;
    end else if (exp_rnd <= EXP_ZERO) begin
      unf_c     = 1'b1;
    end else begin
      res_c.exp  = exp_rnd[7:0];
      res_c.frac = frac_rnd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= res_c;
        out_overflow  <= ovf_c;
        out_underflow <= unf_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed and randomized bench for fp_mul_norm_round with an in-order scoreboard.
module tb_fp_mul_norm_round;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_sign, in_zero;
  logic signed [9:0]  in_exp;
  logic [47:0]        in_mant;
  logic               out_valid, out_ready, out_overflow, out_underflow;
  logic [31:0]        out_result;

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    int          acc_cyc;
    bit          lat_chk;
  } sb_t;

  sb_t   sb[$];
  sb_t   exp_next;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    emitted = 0;
  bit    acc_flag = 0;
  bit    rand_rdy = 0;

  fp_mul_norm_round #(.PROD_W(48), .EXP_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_zero       (in_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: integer significand plus remainder-vs-half comparison.
  function automatic sb_t model(input logic s, input logic signed [9:0] e,
                                input logic [47:0] m, input logic z);
    sb_t         r;
    int          sh, ex;
    logic [47:0] sig, rem, half;
    r = '{32'h0, 1'b0, 1'b0, 0, 1'b0};
    if (z) begin
      r.result = {s, 31'b0};
      return r;
    end
    sh   = m[47] ? 24 : 23;
    ex   = int'(e) + (m[47] ? 1 : 0);
    sig  = m >> sh;
    rem  = m & ((48'd1 << sh) - 48'd1);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && sig[0])) sig = sig + 48'd1;
    if (sig[24]) begin
      sig = sig >> 1;
      ex  = ex + 1;
    end
    if (ex >= 255) begin
      r.result = {s, 8'hFF, 23'b0};
      r.ovf    = 1'b1;
    end else if (ex <= 0) begin
      r.result = {s, 31'b0};
      r.unf    = 1'b1;
    end else begin
      r.result = {s, ex[7:0], sig[22:0]};
    end
    return r;
  endfunction

  // Monitor: sample two time units before each rising edge.
  always @(negedge clk) begin
    sb_t e;
    #3;
    cyc++;
    if (!rst) begin
      if (in_valid && in_ready) begin
        e         = exp_next;
        e.acc_cyc = cyc;
        sb.push_back(e);
        acc_flag  = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_output: observed %h expected none", out_result);
        end else begin
          e = sb.pop_front();
          emitted++;
          check("result", out_result, e.result);
          check("overflow", 32'(out_overflow), 32'(e.ovf));
          check("underflow", 32'(out_underflow), 32'(e.unf));
          if (e.lat_chk) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
        end
      end
    end
  end

  task automatic present(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                         input logic z, input sb_t x);
    @(negedge clk);
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_zero  = z;
    exp_next = x;
    acc_flag = 1'b0;
  endtask

  task automatic wait_acc();
    int n = 0;
    #4;
    while (!acc_flag) begin
      @(negedge clk);
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      #4;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $error("FAIL accept_timeout: observed no accept expected accept");
        break;
      end
    end
  endtask

  task automatic send(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                      input logic z, input logic [31:0] r, input logic o, input logic u,
                      input bit lat);
    present(s, e, m, z, '{r, o, u, 0, lat});
    wait_acc();
  endtask

  task automatic send_m(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                        input logic z, input bit lat);
    sb_t x;
    x         = model(s, e, m, z);
    x.lat_chk = lat;
    present(s, e, m, z, x);
    wait_acc();
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic        rs, rz;
    logic [47:0] rm;
    logic [31:0] hold;
    int          emit_base;

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_zero = 1'b0; out_ready = 1'b1;
    exp_next = '{32'h0, 1'b0, 1'b0, 0, 1'b0};

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'h0);
    check("rst_ovf", 32'(out_overflow), 32'd0);
    check("rst_unf", 32'(out_underflow), 32'd0);
    rst = 1'b0;
    #4 check("rst_in_ready", 32'(in_ready), 32'd1);

    send(1'b0, 10'sd127, 48'h9000_0000_0000, 1'b0, 32'h4010_0000, 1'b0, 1'b0, 1'b1);
    drain();
    send(1'b0, 10'sd127, 48'h4000_0040_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 1'b1);
    send(1'b0, 10'sd127, 48'h4000_00C0_0000, 1'b0, 32'h3F80_0002, 1'b0, 1'b0, 1'b1);
    send(1'b0, 10'sd127, 48'h4000_0040_0001, 1'b0, 32'h3F80_0001, 1'b0, 1'b0, 1'b1);
    send(1'b0, 10'sd127, 48'h7FFF_FFC0_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1'b1);
    send(1'b0, 10'sd255, 48'h4000_0000_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
    send(1'b0, 10'sd254, 48'h7FFF_FFC0_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 1'b1);
    send(1'b1, 10'sd0,   48'h4000_0000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    send(1'b0, -10'sd5,  48'h8000_0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    send(1'b1, 10'sd127, 48'h9000_0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    send(1'b0, 10'sd1,   48'h4000_0000_0000, 1'b0, 32'h0080_0000, 1'b0, 1'b0, 1'b1);
    drain();

    // Stall: two accepts fill the pipe, then in_ready drops and the head holds.
    emit_base = emitted;
    out_ready = 1'b0;
    send(1'b0, 10'sd127, 48'h9000_0000_0000, 1'b0, 32'h4010_0000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 10'sd130, 48'h4000_0000_0000, 1'b0, 32'h4100_0000, 1'b0, 1'b0, 1'b0);
    present(1'b0, 10'sd100, 48'h8000_0000_0000, 1'b0, '{32'h3280_0000, 1'b0, 1'b0, 0, 1'b0});
    #4;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_head", out_result, 32'h4010_0000);
    hold = 32'h4010_0000;
    repeat (2) begin
      @(negedge clk);
      #4;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hold", out_result, hold);
    end
    @(negedge clk);
    out_ready = 1'b1;
    acc_flag  = 1'b0;
    wait_acc();
    send(1'b1, 10'sd127, 48'h6000_0000_0000, 1'b0, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0);
    drain();
    check("stall_emitted", 32'(emitted - emit_base), 32'd4);

    // Randomized traffic with a randomly throttled sink.
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      rz = ($urandom_range(0, 7) == 0);
      rm = 48'({$urandom(), $urandom()});
      if (!rm[47]) rm[46] = 1'b1;
      send_m(rs, 10'($urandom_range(0, 300) - 20), rm, rz, 1'b0);
    end
    rand_rdy = 1'b0;
    drain();

    // Reset with both stages occupied discards everything in flight.
    out_ready = 1'b0;
    send(1'b0, 10'sd127, 48'h9000_0000_0000, 1'b0, 32'h4010_0000, 1'b0, 1'b0, 1'b0);
    send(1'b0, 10'sd128, 48'h9000_0000_0000, 1'b0, 32'h4090_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", out_result, 32'h0);
    sb.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #4 check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    send(1'b1, 10'sd127, 48'h9000_0000_0000, 1'b0, 32'hC010_0000, 1'b0, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
